booth_seq_mult: RTL and testbench
=================================

# booth_seq_mult

Iterative signed multiplier that reuses one classic (radix-2) Booth partial-product slice over WIDTH cycles instead of generating all partial products in parallel. It accepts one operand pair over a valid/ready handshake, scans one Booth digit per cycle, and accumulates the full 2·WIDTH-bit two's-complement product. It then presents the product over a second valid/ready handshake. It sits beside the parallel multiplier as the low-area option for paths that are not throughput-critical.

## Interface
- WIDTH, 16, operand width in bits; must be ≥ 2.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands; equals (state == IDLE).
- in_m  in  WIDTH  multiplicand, signed two's complement.
- in_r  in  WIDTH  multiplier, signed two's complement.
- out_valid  out  1  product valid; high in DONE only.
- out_ready  in  1  consumer accepts product.
- out_p  out  2·WIDTH  signed product in_m × in_r.
- busy  out  1  high in RUN or DONE.

## Operation
- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE:**
  - in_ready = 1.
  - When in_valid & in_ready, latch M = in_m and R = in_r, clear the accumulator, set prev = 0 and cnt = 0, then go to RUN.
- **RUN:** one Booth digit per cycle, i = cnt, digit = {R[i], prev}.
  - 01: acc += sign_ext(M) << i.
  - 10: acc −= sign_ext(M) << i.
  - 00 or 11: acc unchanged.
  - Then prev = R[i] and cnt += 1.
  - After the digit with i = WIDTH−1, copy acc to out_p and go to DONE.
- **Shift-right form is also acceptable.** Add/subtract into the upper WIDTH+1 bits, then arithmetic-shift the combined register right by 1. The bit-exact result must be identical.
- **Arithmetic width:**
  - The adder is at least WIDTH+1 bits so that negating M = −2^(WIDTH−1) does not overflow.
  - The final product is exact over the full signed range, including (−2^(W−1))² = 2^(2W−2).
- **DONE:**
  - out_valid = 1.
  - out_p stays stable until out_valid & out_ready; then go to IDLE.
  - in_valid is ignored.
- **RUN:** in_valid is ignored (in_ready = 0). Inputs in_m and in_r may change freely after acceptance.
- **cnt** is a clog2(WIDTH)-bit counter. It must not wrap before the RUN exit test.
- **Reset, any time including mid-RUN or in DONE:** state = IDLE, out_valid = 0, out_p = 0, busy = 0, in_ready = 1, cnt = 0, acc = 0. An in-flight product is discarded and never presented.
- **out_p outside DONE:** holds the last product (0 after reset). It is meaningful only when out_valid = 1.

## Timing
- Accept on edge k (in_valid & in_ready).
- RUN covers edges k+1 … k+WIDTH. out_valid rises after edge k+WIDTH; latency is WIDTH cycles from acceptance.
- With out_ready held high, the output handshake completes on edge k+WIDTH+1 and in_ready is high again after it.
- The earliest next acceptance is edge k+WIDTH+2, so peak throughput is one product per WIDTH+2 cycles.
- out_valid, out_p, busy and state come from registers.
- in_ready is decoded from state only. There is no combinational path from any input to any output.
- There are no simultaneous in/out handshakes, because in_ready and out_valid are mutually exclusive.

## Test plan
- **Basic latency.** WIDTH = 16, in_m = 3, in_r = 5, out_ready = 1.
  - Expect out_valid exactly 16 cycles after acceptance, with out_p = 0x0000000F.
  - Expect in_ready to return 1 one cycle later.
- **Extreme and sign cases.**
  - 0x8000 × 0x8000 → 0x40000000.
  - 0x7FFF × 0x8000 → 0xC0008000.
  - 0xFFFF × 0x0001 → 0xFFFFFFFF.
  - 0 × 0x8000 → 0.
- **Backpressure.** Hold out_ready = 0 for 20 cycles after out_valid rises.
  - out_valid and out_p stay constant; in_ready stays 0; busy stays 1.
  - Product completes on the first edge with out_ready = 1.
- **Ignored input.** Toggle in_valid and change in_m/in_r during RUN and DONE.
  - No second acceptance occurs; the result equals the product of the originally latched pair.
- **Reset mid-operation.** Assert rst_n = 0 asynchronously at cycle 7 of RUN.
  - Outputs go immediately to out_valid = 0, out_p = 0, busy = 0, in_ready = 1.
  - A new operation after release yields the correct product.
- **Back-to-back random.** Stream 1000 random signed pairs with in_valid and out_ready held high.
  - Every product matches a reference model.
  - Accept-to-accept spacing is exactly 18 cycles.

Source files
------------

// File: rtl/booth_seq_mult_if.sv
// Handshake bundle for the sequential Booth multiplier: one operand channel
// in, one product channel out, plus a busy indicator.
interface booth_seq_mult_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_m;
    logic [WIDTH-1:0]     in_r;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 busy;

    // Producer of operands / consumer of products
    modport master (
        output in_valid, in_m, in_r, out_ready,
        input  in_ready, out_valid, out_p, busy
    );

    // The multiplier itself
    modport slave (
        input  in_valid, in_m, in_r, out_ready,
        output in_ready, out_valid, out_p, busy
    );
endinterface

// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier: one Booth digit per cycle over WIDTH
// cycles, accumulating a full 2*WIDTH-bit signed product in shift-left form.
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_seq_mult_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    p_q, p_d;
    logic             prev_q, prev_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Multiplicand sign-extended to the full product width and weighted by
    // the current digit position; 2*WIDTH bits covers M = -2^(WIDTH-1)
    // negated at any shift, so the final product is exact.
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_nxt;
    logic             r_bit;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and Booth digit accumulation
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        acc_d   = acc_q;
        p_d     = p_q;
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        addend  = {{WIDTH{m_q[WIDTH-1]}}, m_q} << cnt_q;
        r_bit   = r_q[cnt_q];
        acc_nxt = acc_q;

        unique case ({r_bit, prev_q})
            2'b01:   acc_nxt = acc_q + addend;
            2'b10:   acc_nxt = acc_q - addend;
            default: acc_nxt = acc_q;
        endcase

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    m_d     = bus.in_m;
                    r_d     = bus.in_r;
                    acc_d   = '0;
                    prev_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_nxt;
                prev_d = r_bit;
                cnt_d  = cnt_q + CW'(1);
                // Exit is tested on the old count, before it can wrap.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    p_d     = acc_nxt;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All handshake outputs decode from registered state only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_p     = p_q;
endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: vector table, hand-written corner sequences and a
// random back-to-back stream, all checked through an expected-product queue.
module tb_booth_seq_mult;
    localparam int W  = 16;
    localparam int PW = 2 * W;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   n_acc;
    int   last_acc;
    bit   ov_prev;
    bit   stream;
    bit   have_prev;

    logic [PW-1:0] sb[$];

    booth_seq_mult_if #(.WIDTH(W)) bus ();

    booth_seq_mult #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0]  m;
        logic [W-1:0]  r;
        logic [PW-1:0] p;
    } vec_t;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] m, input logic [W-1:0] r);
        longint p;
        p = longint'($signed(m)) * longint'($signed(r));
        return p[PW-1:0];
    endfunction

    // Observer: sees handshakes half a cycle before the edge that takes them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                n_acc++;
                if (stream) begin
                    if (have_prev) check("accept_spacing", 64'(cyc - last_acc), 64'(W + 2));
                    have_prev = 1'b1;
                end
                last_acc = cyc;
            end
            if (bus.out_valid && !ov_prev)
                check("latency", 64'(cyc - last_acc), 64'(W + 1));
            ov_prev = bus.out_valid;
            if (bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_product: got 0x%0h with nothing expected", bus.out_p);
                end else begin
                    logic [PW-1:0] e;
                    e = sb.pop_front();
                    n_tests--;
                    check("product", 64'(bus.out_p), 64'(e));
                end
            end
        end else begin
            ov_prev = 1'b0;
        end
    end

    // Present one pair; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] m, input logic [W-1:0] r,
                        input logic [PW-1:0] exp, input bit keep);
        bit ok;
        ok = 1'b0;
        sb.push_back(exp);
        bus.in_m     = m;
        bus.in_r     = r;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!keep) bus.in_valid = 1'b0;
        check("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && bus.in_ready && !bus.out_valid;
        end
        check("idle_timeout", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.out_valid;
        end
        check("out_valid_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        vec_t          vecs[8];
        logic [PW-1:0] held;
        logic [31:0]   t;
        logic [W-1:0]  m, r;
        int            n0;
        bit            seen;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'h8000, 16'h8000, 32'h40000000};
        vecs[2] = '{16'h7FFF, 16'h8000, 32'hC0008000};
        vecs[3] = '{16'hFFFF, 16'h0001, 32'hFFFFFFFF};
        vecs[4] = '{16'h0000, 16'h8000, 32'h00000000};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
        vecs[7] = '{16'h8000, 16'h7FFF, 32'hC0008000};

        cyc = 0; n_tests = 0; n_fail = 0; n_acc = 0; last_acc = 0;
        stream = 1'b0; have_prev = 1'b0; ov_prev = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_m      = '0;
        bus.in_r      = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_p", 64'(bus.out_p), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic latency and in_ready return
        send(16'd3, 16'd5, 32'h0000000F, 1'b0);
        wait_out_valid();
        check("basic_p", 64'(bus.out_p), 64'h0000000F);
        @(negedge clk);
        check("basic_in_ready_back", 64'(bus.in_ready), 64'd1);
        check("basic_out_valid_low", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Vector table
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].m, vecs[i].r, vecs[i].p, 1'b0);
            wait_idle();
        end

        // Backpressure: product held for 20 cycles
        bus.out_ready = 1'b0;
        send(16'h1234, 16'h5678, 32'h06260060, 1'b0);
        wait_out_valid();
        held = bus.out_p;
        check("bp_p", 64'(held), 64'h06260060);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_p", 64'(bus.out_p), 64'(held));
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_busy", 64'(bus.busy), 64'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_released", 64'(bus.out_valid), 64'd0);
        check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Ignored input during RUN and DONE
        bus.out_ready = 1'b0;
        n0 = n_acc;
        send(16'h0123, 16'hFFD7, model(16'h0123, 16'hFFD7), 1'b0);
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            t = $urandom;
            bus.in_valid = ~bus.in_valid;
            bus.in_m     = t[W-1:0];
            bus.in_r     = t[31:32-W];
        end
        bus.in_valid = 1'b0;
        check("ignored_accepts", 64'(n_acc - n0), 64'd1);
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset seven cycles into RUN
        send(16'h2345, 16'h0ABC, model(16'h2345, 16'h0ABC), 1'b0);
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_out_p", 64'(bus.out_p), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid_rst_no_stale", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        send(16'hF00D, 16'h00B5, model(16'hF00D, 16'h00B5), 1'b0);
        wait_idle();

        // Back-to-back random stream
        stream    = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            t = $urandom;
            m = t[W-1:0];
            r = t[31:32-W];
            send(m, r, model(m, r), 1'b1);
        end
        bus.in_valid = 1'b0;
        wait_idle();
        stream = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
